// File: rtl/acc_sampler.sv
// Decimating sampler: tags every DECIM-cycle window with an overflow flag and queues samples in a FWFT FIFO.
// Optional saturating overflow-window counter enabled by defining ACC_SAMPLER_OVF_CNT_EN.
module acc_sampler #(
  parameter int NB_DATA    = 6,
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int NB_OVF_CNT = 8
) (
  input  logic                                clk,
  input  logic                                i_rst,
  input  logic                                i_enable,
  input  logic [NB_DATA-1:0]                  i_data,
  input  logic                                i_overflow,
  output logic [NB_DATA:0]                    o_data,
  output logic                                o_valid,
  input  logic                                i_ready,
  output logic                                o_full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     o_level,
  output logic                                o_drop,
  output logic [NB_OVF_CNT-1:0]               o_ovf_cnt
);

  localparam int NB_WCNT = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int NB_PTR  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NB_LVL  = $clog2(FIFO_DEPTH + 1);
  localparam logic [NB_WCNT-1:0] WCNT_LAST = NB_WCNT'(DECIM - 1);
  localparam logic [NB_LVL-1:0]  LVL_FULL  = NB_LVL'(FIFO_DEPTH);

  logic [NB_WCNT-1:0] wcnt_reg, wcnt_next;
  logic               ovf_acc_reg, ovf_acc_next;
  logic [NB_PTR-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [NB_PTR-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [NB_LVL-1:0]  level_reg, level_next;
  logic [NB_DATA:0]   data_reg, data_next;
  logic               drop_reg, drop_next;

  logic               sample;
  logic               flag;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic [NB_DATA:0]   push_word;

  logic [NB_DATA:0]   mem [FIFO_DEPTH];

  always_comb begin
    full      = (level_reg == LVL_FULL);
    empty     = (level_reg == '0);
    pop       = !empty && i_ready;
    sample    = i_enable && (wcnt_reg == WCNT_LAST);
    flag      = ovf_acc_reg | i_overflow;
    push_word = {flag, i_data};
    // A full FIFO still accepts the sample when the head leaves on the same edge.
    push      = sample && (!full || pop);

    wcnt_next    = wcnt_reg;
    ovf_acc_next = ovf_acc_reg;
    if (!i_enable || sample) begin
      wcnt_next    = '0;
      ovf_acc_next = 1'b0;
    end else begin
      wcnt_next    = wcnt_reg + NB_WCNT'(1);
      ovf_acc_next = flag;
    end

    wr_ptr_next = push ? wr_ptr_reg + NB_PTR'(1) : wr_ptr_reg;
    rd_ptr_next = pop  ? rd_ptr_reg + NB_PTR'(1) : rd_ptr_reg;

    level_next = level_reg;
    if (push && !pop)
      level_next = level_reg + NB_LVL'(1);
    else if (pop && !push)
      level_next = level_reg - NB_LVL'(1);

    drop_next = drop_reg | (sample && !push);

    // Head register: reload when the head moves or the first word lands; bypass a same-edge write.
    data_next = data_reg;
    if ((level_next != '0) && (pop || empty)) begin
      if (push && (wr_ptr_reg == rd_ptr_next))
        data_next = push_word;
      else
        data_next = mem[rd_ptr_next];
    end
  end

  always_ff @(posedge clk) begin
    if (push && !i_rst)
      mem[wr_ptr_reg] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      wcnt_reg    <= '0;
      ovf_acc_reg <= 1'b0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      level_reg   <= '0;
      data_reg    <= '0;
      drop_reg    <= 1'b0;
    end else begin
      wcnt_reg    <= wcnt_next;
      ovf_acc_reg <= ovf_acc_next;
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      level_reg   <= level_next;
      data_reg    <= data_next;
      drop_reg    <= drop_next;
    end
  end

`ifdef ACC_SAMPLER_OVF_CNT_EN
  logic [NB_OVF_CNT-1:0] ovf_cnt_reg;

  // Counts flagged sample events whether or not the word fit in the FIFO.
  always_ff @(posedge clk) begin
    if (i_rst)
      ovf_cnt_reg <= '0;
    else if (sample && flag && (ovf_cnt_reg != '1))
      ovf_cnt_reg <= ovf_cnt_reg + NB_OVF_CNT'(1);
  end

  assign o_ovf_cnt = ovf_cnt_reg;
`else
  assign o_ovf_cnt = '0;
`endif

  assign o_data  = data_reg;
  assign o_valid = !empty;
  assign o_full  = full;
  assign o_level = level_reg;
  assign o_drop  = drop_reg;

endmodule

// File: tb/tb_acc_sampler.sv
// Testbench for acc_sampler: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_acc_sampler;

  localparam int NBD   = 6;
  localparam int DEC   = 4;
  localparam int DEPTH = 4;
  localparam int NBC   = 2;
  localparam int NBL   = $clog2(DEPTH + 1);
  localparam int CMAX  = (1 << NBC) - 1;

`ifdef ACC_SAMPLER_OVF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             i_rst;
  logic             i_enable;
  logic [NBD-1:0]   i_data;
  logic             i_overflow;
  logic [NBD:0]     o_data;
  logic             o_valid;
  logic             i_ready;
  logic             o_full;
  logic [NBL-1:0]   o_level;
  logic             o_drop;
  logic [NBC-1:0]   o_ovf_cnt;

  acc_sampler #(
    .NB_DATA(NBD), .DECIM(DEC), .FIFO_DEPTH(DEPTH), .NB_OVF_CNT(NBC)
  ) dut (
    .clk(clk), .i_rst(i_rst), .i_enable(i_enable), .i_data(i_data),
    .i_overflow(i_overflow), .o_data(o_data), .o_valid(o_valid),
    .i_ready(i_ready), .o_full(o_full), .o_level(o_level),
    .o_drop(o_drop), .o_ovf_cnt(o_ovf_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [NBD:0] m_q[$];
  logic [NBD:0] m_last;
  int           m_win;
  bit           m_ovf;
  bit           m_drop;
  int           m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Effect of the coming clock edge on the reference model.
  task automatic model_step(input logic rst, input logic en, input logic ovf,
                            input logic rdy, input logic [NBD-1:0] d);
    bit is_sample;
    bit flg;
    if (rst) begin
      m_q.delete();
      m_last = '0;
      m_win  = 0;
      m_ovf  = 0;
      m_drop = 0;
      m_cnt  = 0;
      return;
    end
    is_sample = en && (m_win == DEC - 1);
    flg       = m_ovf || ovf;
    if (m_q.size() > 0 && rdy) begin
      m_last = m_q.pop_front();
      $display("accept word=%02h flag=%0d data=%0d t=%0t", m_last, m_last[NBD], m_last[NBD-1:0], $time);
    end
    if (is_sample) begin
      if (m_q.size() < DEPTH) m_q.push_back({flg, d});
      else m_drop = 1;
      if (flg && m_cnt < CMAX) m_cnt++;
    end
    if (!en || is_sample) begin
      m_win = 0;
      m_ovf = 0;
    end else begin
      m_win++;
      m_ovf = flg;
    end
  endtask

  task automatic check_all();
    chk("valid",   32'(o_valid),   32'(m_q.size() > 0));
    chk("data",    32'(o_data),    32'((m_q.size() > 0) ? m_q[0] : m_last));
    chk("level",   32'(o_level),   32'(m_q.size()));
    chk("full",    32'(o_full),    32'(m_q.size() == DEPTH));
    chk("drop",    32'(o_drop),    32'(m_drop));
    chk("ovf_cnt", 32'(o_ovf_cnt), CNT_EN ? 32'(m_cnt) : 32'd0);
  endtask

  task automatic cycle(input logic rst, input logic en, input logic ovf,
                       input logic rdy, input logic [NBD-1:0] d);
    i_rst      = rst;
    i_enable   = en;
    i_overflow = ovf;
    i_ready    = rdy;
    i_data     = d;
    model_step(rst, en, ovf, rdy, d);
    @(negedge clk);
    check_all();
  endtask

  int sat_exp [5] = '{1, 2, 3, 3, 3};

  initial begin
    i_rst = 1'b1; i_enable = 1'b0; i_overflow = 1'b0; i_ready = 1'b0; i_data = '0;
    m_last = '0; m_win = 0; m_ovf = 0; m_drop = 0; m_cnt = 0;
    @(negedge clk);

    // Basic sampling
    cycle(1, 0, 0, 1, 0);
    for (int k = 0; k < 13; k++) begin
      cycle(0, 1, 0, 1, NBD'(k));
      if (k == 3 || k == 7 || k == 11) begin
        chk("basic_valid", 32'(o_valid), 32'd1);
        chk("basic_word", 32'(o_data), 32'(k));
      end
      if (k == 4 || k == 8) chk("basic_one_cycle", 32'(o_valid), 32'd0);
    end

    // Overflow flag
    cycle(1, 0, 0, 1, 0);
    for (int k = 0; k < 13; k++) begin
      cycle(0, 1, (k == 5), 1, NBD'(k));
      if (k == 3)  chk("ovf_word0", 32'(o_data), 32'h03);
      if (k == 7)  chk("ovf_word1", 32'(o_data), 32'h47);
      if (k == 11) chk("ovf_word2", 32'(o_data), 32'h0b);
    end
    chk("ovf_cnt_one", 32'(o_ovf_cnt), CNT_EN ? 32'd1 : 32'd0);

    // Backpressure with drops, then drain
    cycle(1, 0, 0, 0, 0);
    for (int k = 0; k < 28; k++) begin
      cycle(0, 1, 0, (k >= 24), NBD'(k));
      if (k == 15) chk("bp_full", 32'(o_full), 32'd1);
      if (k == 23) begin
        chk("bp_drop", 32'(o_drop), 32'd1);
        chk("bp_head", 32'(o_data), 32'd3);
      end
      if (k == 24) chk("bp_drain7",  32'(o_data), 32'd7);
      if (k == 25) chk("bp_drain11", 32'(o_data), 32'd11);
      if (k == 26) chk("bp_drain15", 32'(o_data), 32'd15);
    end
    chk("bp_drop_sticky", 32'(o_drop), 32'd1);

    // Full with simultaneous pop on the sample cycle
    cycle(1, 0, 0, 0, 0);
    for (int k = 0; k < 23; k++) begin
      cycle(0, 1, 0, (k >= 19), NBD'(k));
      if (k == 19) begin
        chk("fp_level", 32'(o_level), 32'd4);
        chk("fp_nodrop", 32'(o_drop), 32'd0);
        chk("fp_head7", 32'(o_data), 32'd7);
      end
      if (k == 20) chk("fp_head11", 32'(o_data), 32'd11);
      if (k == 21) chk("fp_head15", 32'(o_data), 32'd15);
      if (k == 22) chk("fp_head19", 32'(o_data), 32'd19);
    end

    // Reset mid-operation
    cycle(1, 0, 0, 0, 0);
    for (int k = 0; k < 9; k++) cycle(0, 1, (k == 1), 0, NBD'(k));
    chk("rm_level2", 32'(o_level), 32'd2);
    chk("rm_cnt1", 32'(o_ovf_cnt), CNT_EN ? 32'd1 : 32'd0);
    cycle(1, 1, 0, 1, 0);
    chk("rm_valid0", 32'(o_valid), 32'd0);
    chk("rm_level0", 32'(o_level), 32'd0);
    chk("rm_cnt0", 32'(o_ovf_cnt), 32'd0);
    chk("rm_data0", 32'(o_data), 32'd0);
    for (int k = 0; k < 4; k++) cycle(0, 1, 0, 1, NBD'(k));
    chk("rm_first", 32'(o_data), 32'h03);

    // Counter saturation
    cycle(1, 0, 0, 1, 0);
    for (int k = 0; k < 20; k++) begin
      cycle(0, 1, 1, 1, NBD'(k));
      if (k % DEC == DEC - 1)
        chk("sat_cnt", 32'(o_ovf_cnt), CNT_EN ? 32'(sat_exp[k / DEC]) : 32'd0);
    end

    // Enable gap restarts the window
    cycle(1, 0, 0, 1, 0);
    cycle(0, 1, 0, 1, 0);
    cycle(0, 1, 0, 1, 1);
    for (int g = 0; g < 3; g++) cycle(0, 0, 0, 1, 6'h2a);
    for (int k = 2; k < 6; k++) begin
      cycle(0, 1, 0, 1, NBD'(k));
      if (k < 5) chk("gap_novalid", 32'(o_valid), 32'd0);
      else chk("gap_word", 32'(o_data), 32'd5);
    end

    // Randomized traffic
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      logic r_rst, r_en, r_ovf, r_rdy;
      r_rst = ($urandom_range(0, 199) == 0);
      r_en  = ($urandom_range(0, 7) != 0);
      r_ovf = ($urandom_range(0, 9) == 0);
      r_rdy = ((i / 300) % 2 == 1) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 3) != 0);
      cycle(r_rst, r_en, r_ovf, r_rdy, NBD'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
